// File: rtl/alu_handshake_unit.sv
// Handshaked ALU execution unit: one request in, one registered result out.
// Define ALU_SERIAL_ADD_EN to compute ADD/SUB/TCP nibble-serially in the CALC state.
module alu_handshake_unit #(
    parameter int NumBits = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [NumBits-1:0] A,
    input  logic [NumBits-1:0] B,
    input  logic [3:0]         FuncCode,
    output logic               RespValid,
    input  logic               RespReady,
    output logic [NumBits-1:0] C,
    output logic               OverflowFlag,
    output logic               Busy
);

    localparam int NumNibbles = NumBits / 4;
    localparam int IdxW       = (NumNibbles > 1) ? $clog2(NumNibbles) : 1;
    localparam int Msb        = NumBits - 1;

    localparam logic [NumBits-1:0] One     = NumBits'(1);
    localparam logic [IdxW-1:0]    LastIdx = IdxW'(NumNibbles - 1);
    localparam logic [3:0]         FnAdd   = 4'd0;
    localparam logic [3:0]         FnSub   = 4'd1;
    localparam logic [3:0]         FnTcp   = 4'd14;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_e;

    state_e             state_q;
    logic [NumBits-1:0] opA_q;
    logic [NumBits-1:0] opB_q;
    logic [3:0]         func_q;
    logic [IdxW-1:0]    nibIdx_q;
    logic               carry_q;
    logic [NumBits-1:0] c_q;
    logic               of_q;
    logic               respValid_q;

    logic [NumBits-1:0] aluC;
    logic               aluOf;
    logic [NumBits-1:0] serX;
    logic [NumBits-1:0] serY;
    logic [NumBits-1:0] cNext;
    logic [4:0]         serSum;
    logic               serOf;
    logic               useSerial;

    always_comb begin
        aluC = '0;
        case (FuncCode)
            4'd0:    aluC = A + B;
            4'd1:    aluC = A + ~B + One;
            4'd2:    aluC = A;
            4'd3:    aluC = ~A;
            4'd4:    aluC = A & B;
            4'd5:    aluC = A | B;
            4'd6:    aluC = ~(A & B);
            4'd7:    aluC = ~(A | B);
            4'd8:    aluC = A ^ B;
            4'd9:    aluC = ~(A ^ B);
            4'd10:   aluC = A << 1;
            4'd11:   aluC = A >> 1;
            4'd12:   aluC = A << 1;
            4'd13:   aluC = {A[Msb], A[Msb:1]};
            4'd14:   aluC = ~A + One;
            default: aluC = '0;
        endcase
        aluOf = ((FuncCode == FnAdd) && (A[Msb] == B[Msb]) && (aluC[Msb] != A[Msb]))
             || ((FuncCode == FnSub) && (A[Msb] != B[Msb]) && (aluC[Msb] != A[Msb]));
    end

    // Serial datapath: TCP is treated as 0 + ~A with carry-in 1, SUB as A + ~B with carry-in 1.
    always_comb begin
        serX = (func_q == FnTcp) ? '0 : opA_q;
        case (func_q)
            FnSub:   serY = ~opB_q;
            FnTcp:   serY = ~opA_q;
            default: serY = opB_q;
        endcase
        serSum = {1'b0, serX[{nibIdx_q, 2'b00} +: 4]}
               + {1'b0, serY[{nibIdx_q, 2'b00} +: 4]}
               + {4'b0000, carry_q};
        cNext = c_q;
        cNext[{nibIdx_q, 2'b00} +: 4] = serSum[3:0];
        serOf = ((func_q == FnAdd) && (opA_q[Msb] == opB_q[Msb]) && (cNext[Msb] != opA_q[Msb]))
             || ((func_q == FnSub) && (opA_q[Msb] != opB_q[Msb]) && (cNext[Msb] != opA_q[Msb]));
    end

`ifdef ALU_SERIAL_ADD_EN
    assign useSerial = (FuncCode == FnAdd) || (FuncCode == FnSub) || (FuncCode == FnTcp);
`else
    assign useSerial = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            func_q      <= '0;
            nibIdx_q    <= '0;
            carry_q     <= 1'b0;
            c_q         <= '0;
            of_q        <= 1'b0;
            respValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ReqValid) begin
                        opA_q  <= A;
                        opB_q  <= B;
                        func_q <= FuncCode;
                        if (useSerial) begin
                            nibIdx_q <= '0;
                            carry_q  <= (FuncCode != FnAdd);
                            state_q  <= CALC;
                        end else begin
                            c_q         <= aluC;
                            of_q        <= aluOf;
                            respValid_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                CALC: begin
                    c_q      <= cNext;
                    carry_q  <= serSum[4];
                    nibIdx_q <= nibIdx_q + IdxW'(1);
                    if (nibIdx_q == LastIdx) begin
                        of_q        <= serOf;
                        respValid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        respValid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReqReady     = (state_q == IDLE);
    assign Busy         = (state_q != IDLE);
    assign RespValid    = respValid_q;
    assign C            = c_q;
    assign OverflowFlag = of_q;

endmodule
